// File: rtl/reg_bank.sv
// reg_bank: multi-ported register bank with a self-clearing start-up sequence.
//
// After reset, or on a clear_all request, the bank walks every entry and
// writes zero to it, one entry per cycle (state CLEAR). It then enters RUN,
// where it takes one write and serves two independent combinational reads
// per cycle.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (restarts the clear sequence)
//   clear_all  in RUN, drop this cycle's write and restart the clear sequence
//   reg_write  write enable
//   dir_WR     write address
//   data_in    write data
//   dirA/dirB  read addresses for ports A and B
//   datA/datB  combinational read data (0 while ready is low)
//   ready      registered: 1 in RUN, 0 in CLEAR
//   wr_drop    registered pulse: the previous cycle's reg_write was discarded
//   fsm_state  current FSM state (0 = CLEAR, 1 = RUN), for observation
//
// Handshake: the bank has no back-pressure. A write is taken on the rising
// edge when reg_write = 1 and the bank is ready, clear_all = 0, and the target
// is not a hardwired-zero entry. Any other reg_write = 1 is discarded and
// flagged by wr_drop on the following cycle; nothing is held or retried.
module reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_all,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] dir_WR,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] dirA,
  input  logic [ADDR_W-1:0] dirB,
  output logic [DATA_W-1:0] datA,
  output logic [DATA_W-1:0] datB,
  output logic              ready,
  output logic              wr_drop,
  output logic              fsm_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              zero_wr;
  logic              wr_accept;

  assign fsm_state = state;

  // Writes to the hardwired-zero entry never land in the array.
  assign zero_wr   = (ZERO_REG != 0) && (dir_WR == '0);
  assign wr_accept = !rst && (state == RUN) && reg_write && !clear_all && !zero_wr;

  // Control FSM. ready is registered alongside the state so it always
  // matches the state it decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= reg_write && !wr_accept;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          // Last entry is zeroed on this edge; serve requests from the next cycle.
          if (clr_ptr == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clear_all) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage. No reset on the array itself: zeroing is done by the CLEAR walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_accept) begin
        mem[dir_WR] <= data_in;
      end
    end
  end

  // Read ports. Priority, lowest to highest: stored value, same-cycle bypass,
  // hardwired zero, not-ready masking.
  always_comb begin
    datA = mem[dirA];
    if ((BYPASS != 0) && wr_accept && (dirA == dir_WR)) begin
      datA = data_in;
    end
    if ((ZERO_REG != 0) && (dirA == '0)) begin
      datA = '0;
    end
    if (!ready) begin
      datA = '0;
    end
  end

  always_comb begin
    datB = mem[dirB];
    if ((BYPASS != 0) && wr_accept && (dirB == dir_WR)) begin
      datB = data_in;
    end
    if ((ZERO_REG != 0) && (dirB == '0)) begin
      datB = '0;
    end
    if (!ready) begin
      datB = '0;
    end
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and data port in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 0: 1 = entry 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1: 1 = write data is forwarded to read ports in the same cycle.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port clear_all  input  1  request to re-zero all entries while running.
REQ-008 Port reg_write  input  1  write enable.
REQ-009 Port dir_WR  input  ADDR_W  write address.
REQ-010 Port data_in  input  DATA_W  write data.
REQ-011 Port dirA  input  ADDR_W  read port A address.
REQ-012 Port dirB  input  ADDR_W  read port B address.
REQ-013 Port datA  output  DATA_W  read port A data, combinational.
REQ-014 Port datB  output  DATA_W  read port B data, combinational.
REQ-015 Port ready  output  1  high when the bank accepts writes and returns stored data.
REQ-016 Port wr_drop  output  1  registered pulse: previous cycle's reg_write was discarded.

Function
REQ-017 The block SHALL have two states: CLEAR and RUN.
REQ-018 CLEAR: an internal pointer clr_ptr starts at 0, writes zero to entry clr_ptr each cycle, and increments by 1.
REQ-019 CLEAR SHALL transition to RUN on the cycle after clr_ptr = DEPTH-1 is written; clear takes exactly DEPTH cycles.
REQ-020 RUN SHALL transition to CLEAR, with clr_ptr = 0, on any cycle where clear_all = 1.
REQ-021 ready SHALL be 1 in RUN and 0 in CLEAR; ready is a registered state decode.
REQ-022 In RUN, with reg_write = 1 and clear_all = 0, data_in SHALL be stored at dir_WR on the rising edge.
REQ-023 A write is dropped (no array change, wr_drop = 1 next cycle) under any of these conditions: state is CLEAR; clear_all = 1 in the same cycle; or ZERO_REG = 1 and dir_WR = 0.
REQ-024 wr_drop SHALL be 0 in every other cycle, including cycles with reg_write = 0.
REQ-025 Reads return array[dirA] and array[dirB] combinationally; both ports are independent and may address the same entry.
REQ-026 While ready = 0, datA and datB SHALL read 0 regardless of array contents.
REQ-027 When ZERO_REG = 1, reads of address 0 SHALL return 0 at all times.
REQ-028 Bypass: if BYPASS = 1, the write is accepted this cycle, and dirA = dir_WR, then datA = data_in in that same cycle; datB follows the same rule with dirB. Bypass does not apply when ZERO_REG = 1 and the address is 0.
REQ-029 When BYPASS = 0, a read of the address being written SHALL return the old value until the next edge.
REQ-030 Data is stored unmodified, with no truncation or extension; each entry is exactly DATA_W bits.

Reset
REQ-031 rst = 1 SHALL force state = CLEAR, clr_ptr = 0, ready = 0 and wr_drop = 0 at the next rising edge.
REQ-032 rst SHALL take priority over clear_all, reg_write and any CLEAR/RUN transition.
REQ-033 Array contents are defined only after a full CLEAR completes.
REQ-034 rst asserted mid-CLEAR SHALL restart the clear from entry 0.
REQ-035 After rst deasserts, ready SHALL rise exactly DEPTH cycles later if clear_all stays 0.
REQ-036 No initial blocks are used for array contents; zeroing happens only through CLEAR.

Verification
REQ-037 Reset release: rst 1 for 2 cycles, then 0 -> ready = 0 for 16 cycles, then 1; all 16 entries read 0 on both ports.
REQ-038 Write/read: in RUN, write 0xDEADBEEF to address 5 -> next cycle dirA = 5 and dirB = 5 both read 0xDEADBEEF.
REQ-039 Bypass: BYPASS = 1, write 0x12345678 to address 3 with dirA = 3 -> datA = 0x12345678 in the same cycle. With BYPASS = 0 -> datA shows the old value, then 0x12345678 after the edge.
REQ-040 ZERO_REG = 1: write 0xFFFFFFFF to address 0 -> wr_drop = 1 next cycle, and datA with dirA = 0 reads 0.
REQ-041 clear_all with simultaneous write of 0xAA to address 7 -> wr_drop = 1, ready = 0 for 16 cycles, then address 7 reads 0.
REQ-042 Mid-clear reset: assert rst when clr_ptr = 9 -> clear restarts, and ready rises exactly 16 cycles after rst deasserts.
